// File: rtl/arb_pkg.sv
// Shared types and sizing for the 8-way round-robin arbiter.
package arb_pkg;

   localparam int unsigned N_REQ = 8;
   localparam int unsigned IDX_W = 3;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

   // Binary index to one-hot request/grant vector.
   function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
      onehot      = '0;
      onehot[idx] = 1'b1;
   endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotating-priority picker: first set request at or after ptr.
module rr_priority_pick
   import arb_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic [IDX_W-1:0] win_idx,
   output logic             found
);

   logic [N_REQ-1:0] rot;
   logic [IDX_W-1:0] off;

   // Rotate right by ptr so the highest-priority requester lands in bit 0.
   always_comb begin
      rot = '0;
      for (int i = 0; i < N_REQ; i++) begin
         rot[i] = req[IDX_W'(i) + ptr];
      end
   end

   // Lowest set bit of the rotated vector, mapped back by adding ptr (wraps mod N_REQ).
   always_comb begin
      off   = '0;
      found = |rot;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (rot[i]) off = IDX_W'(i);
      end
      win_idx = off + ptr;
   end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter: registered one-hot grant, held until done, dropped
// request, or hold limit; priority pointer advances past the owner on release.
module rr_arbiter8
   import arb_pkg::*;
#(
   parameter int unsigned HOLD_MAX = 16
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   input  logic             done,
   output logic [N_REQ-1:0] gnt,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             gnt_valid,
   output logic             timeout
);

   // state | meaning
   // IDLE  | no grant held; waiting for any request
   // GRANT | gnt_idx owns the resource until done / req drop / hold limit

   localparam int unsigned HCNT_W = (HOLD_MAX < 2) ? 1 : $clog2(HOLD_MAX);
   localparam logic [HCNT_W-1:0] HOLD_LAST =
      (HOLD_MAX == 0) ? '0 : HCNT_W'(HOLD_MAX - 1);

   arb_state_e        state_q, state_d;
   logic [IDX_W-1:0]  ptr_q, ptr_d;
   logic [HCNT_W-1:0] hold_cnt_q, hold_cnt_d;
   logic [N_REQ-1:0]  gnt_q, gnt_d;
   logic [IDX_W-1:0]  gnt_idx_q, gnt_idx_d;
   logic              gnt_valid_q, gnt_valid_d;
   logic              timeout_q, timeout_d;

   logic [IDX_W-1:0]  pick_ptr;
   logic [IDX_W-1:0]  win_idx;
   logic              found;
   logic              owner_req;
   logic              limit_hit;
   logic              release_grant;

   // In GRANT the search starts just past the owner, so a release and the
   // next grant can share one edge without waiting for ptr_q to update.
   assign pick_ptr = (state_q == GRANT) ? (gnt_idx_q + 1'b1) : ptr_q;

   rr_priority_pick u_pick (
      .req     (req),
      .ptr     (pick_ptr),
      .win_idx (win_idx),
      .found   (found)
   );

   assign owner_req     = req[gnt_idx_q];
   assign limit_hit     = (HOLD_MAX != 0) && (hold_cnt_q == HOLD_LAST);
   assign release_grant = done || !owner_req || limit_hit;

   // Next-state and output decode.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      hold_cnt_d  = hold_cnt_q;
      gnt_d       = gnt_q;
      gnt_idx_d   = gnt_idx_q;
      gnt_valid_d = gnt_valid_q;
      timeout_d   = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (found) begin
               gnt_d       = onehot(win_idx);
               gnt_idx_d   = win_idx;
               gnt_valid_d = 1'b1;
               hold_cnt_d  = '0;
               state_d     = GRANT;
            end
         end
         GRANT: begin
            if (release_grant) begin
               ptr_d     = gnt_idx_q + 1'b1;
               // done or a dropped request outranks the hold limit as the cause
               timeout_d = limit_hit && !done && owner_req;
               if (found) begin
                  gnt_d      = onehot(win_idx);
                  gnt_idx_d  = win_idx;
                  hold_cnt_d = '0;
               end else begin
                  gnt_d       = '0;
                  gnt_idx_d   = '0;
                  gnt_valid_d = 1'b0;
                  state_d     = IDLE;
               end
            end else if (hold_cnt_q != '1) begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, pointer, counter and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         hold_cnt_q  <= '0;
         gnt_q       <= '0;
         gnt_idx_q   <= '0;
         gnt_valid_q <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         hold_cnt_q  <= hold_cnt_d;
         gnt_q       <= gnt_d;
         gnt_idx_q   <= gnt_idx_d;
         gnt_valid_q <= gnt_valid_d;
         timeout_q   <= timeout_d;
      end
   end

   assign gnt       = gnt_q;
   assign gnt_idx   = gnt_idx_q;
   assign gnt_valid = gnt_valid_q;
   assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8: directed scenarios plus random traffic, checked
// against a cycle-level model built from the round-robin rules.
module tb_rr_arbiter8;
   import arb_pkg::*;

   localparam int HM = 16;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [N_REQ-1:0] req = '0;
   logic             done = 1'b0;
   logic [N_REQ-1:0] gnt;
   logic [IDX_W-1:0] gnt_idx;
   logic             gnt_valid;
   logic             timeout;

   int checks = 0;
   int failures = 0;

   // Reference model state.
   int m_ptr, m_owner, m_hold;
   bit m_valid, m_to;

   rr_arbiter8 #(.HOLD_MAX(HM)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .done      (done),
      .gnt       (gnt),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid),
      .timeout   (timeout)
   );

   always #5 clk = ~clk;

   function automatic int find_win(int p, logic [7:0] r);
      for (int k = 0; k < 8; k++) begin
         if (r[(p + k) % 8]) return (p + k) % 8;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_ptr = 0; m_owner = 0; m_hold = 0; m_valid = 0; m_to = 0;
   endtask

   task automatic model_step();
      int w;
      bit lim, rel;
      m_to = 0;
      if (!m_valid) begin
         w = find_win(m_ptr, req);
         if (w >= 0) begin
            m_valid = 1; m_owner = w; m_hold = 0;
         end
      end else begin
         lim = (HM != 0) && (m_hold == HM - 1);
         rel = done || !req[m_owner] || lim;
         if (rel) begin
            m_to  = lim && !done && req[m_owner];
            m_ptr = (m_owner + 1) % 8;
            w = find_win(m_ptr, req);
            if (w >= 0) begin
               m_owner = w; m_hold = 0;
            end else begin
               m_valid = 0; m_owner = 0;
            end
         end else begin
            m_hold++;
         end
      end
   endtask

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_model(string tag);
      logic [7:0] e;
      e = '0;
      if (m_valid) e[m_owner] = 1'b1;
      chk({tag, "_gnt"}, 32'(gnt), 32'(e));
      chk({tag, "_idx"}, 32'(gnt_idx), m_valid ? 32'(m_owner) : 32'd0);
      chk({tag, "_valid"}, 32'(gnt_valid), 32'(m_valid));
      chk({tag, "_timeout"}, 32'(timeout), 32'(m_to));
   endtask

   task automatic step(string tag);
      model_step();
      @(posedge clk);
      #1;
      chk_model(tag);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      model_reset();
      chk_model("rst_async");
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      // 1: reset, then idle with no requests
      model_reset();
      #1;
      chk_model("t1_in_reset");
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      req = 8'h00;
      for (int i = 0; i < 5; i++) step("t1_idle");

      // 2: single requester, done release, ptr advanced to 3
      req = 8'b0000_0100;
      step("t2_grant");
      chk("t2_gnt_const", 32'(gnt), 32'h04);
      chk("t2_idx_const", 32'(gnt_idx), 32'd2);
      done = 1'b1;
      req  = 8'h00;
      step("t2_done");
      chk("t2_gnt_zero", 32'(gnt), 32'h00);
      done = 1'b0;
      req  = 8'h05;
      step("t2_ptr3");
      chk("t2_ptr3_idx", 32'(gnt_idx), 32'd0);
      done = 1'b1;
      req  = 8'h00;
      step("t2_rel");
      done = 1'b0;

      // 3: all requesting, done every cycle -> back-to-back rotation
      do_reset();
      req = 8'hFF;
      step("t3_first");
      chk("t3_first_idx", 32'(gnt_idx), 32'd0);
      done = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         step("t3_rot");
         chk("t3_rot_idx", 32'(gnt_idx), 32'(i % 8));
         chk("t3_rot_valid", 32'(gnt_valid), 32'd1);
      end

      // 4: steer ptr to 7, then wrap-around 7 -> 0
      req  = 8'h40;
      step("t4_to6");
      req  = 8'h00;
      step("t4_idle");
      done = 1'b0;
      req  = 8'h81;
      step("t4_g7");
      chk("t4_idx7", 32'(gnt_idx), 32'd7);
      done = 1'b1;
      step("t4_wrap");
      chk("t4_idx0", 32'(gnt_idx), 32'd0);
      done = 1'b0;
      req  = 8'h00;
      step("t4_drop");

      // 5: hold limit with sole requester
      do_reset();
      req = 8'h10;
      step("t5_grant");
      for (int i = 1; i < HM; i++) begin
         step("t5_hold");
         chk("t5_no_to", 32'(timeout), 32'd0);
      end
      step("t5_limit");
      chk("t5_to_pulse", 32'(timeout), 32'd1);
      chk("t5_regrant", 32'(gnt), 32'h10);
      step("t5_after");
      chk("t5_to_once", 32'(timeout), 32'd0);
      for (int i = 0; i < HM + 4 && m_hold != HM - 1; i++) step("t5_rehold");
      done = 1'b1;
      step("t5_done_wins");
      chk("t5_done_no_to", 32'(timeout), 32'd0);
      done = 1'b0;

      // 6: reset mid-grant
      do_reset();
      req = 8'h20;
      step("t6_grant");
      chk("t6_gnt20", 32'(gnt), 32'h20);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("t6_async_gnt", 32'(gnt), 32'h00);
      chk("t6_async_valid", 32'(gnt_valid), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step("t6_regrant");
      chk("t6_regrant_gnt", 32'(gnt), 32'h20);

      // Random traffic with persistent requests and occasional done.
      do_reset();
      req = 8'(1 + $urandom_range(0, 254));
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 7) == 0) req = 8'($urandom_range(0, 255));
         done = ($urandom_range(0, 5) == 0);
         step("rnd");
      end
      done = 1'b0;
      req  = 8'h00;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
